// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST engine.
package mem_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WRITE,
      READ,
      CHECK,
      DONE
   } mem_bist_state_t;

   // Per-bit seed of the pattern register; the first test write uses its inverse.
   localparam logic PATTERN_INIT = 1'b0;

   // True when addr is the last word of the array, which ends a phase.
   function automatic logic is_last_addr(input int unsigned addr, input int unsigned depth);
      return addr == depth - 1;
   endfunction

endpackage

// File: rtl/mem_bist_err_log.sv
// Read-back comparator and result registers: error count and first failing address.
module mem_bist_err_log #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_output,
   input  logic [DATA_WIDTH-1:0] pattern,
   output logic [ADDR_WIDTH:0]   error_count,
   output logic                  first_fail_valid,
   output logic [ADDR_WIDTH-1:0] first_fail_addr
);

   localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

   logic mismatch;

   // Any differing bit marks the word as failing.
   always_comb begin
      mismatch = 1'b0;
      if (enable) mismatch = (data_output != pattern);
   end

   // Count failing words and latch the first failing address of the run.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         error_count      <= '0;
         first_fail_valid <= 1'b0;
         first_fail_addr  <= '0;
      end else if (mismatch) begin
         error_count <= error_count + COUNT_WIDTH'(1);
         if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_addr  <= address;
         end
      end
   end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST engine: clears the array, then writes, reads back and compares
// every word with an alternating all-ones / all-zeros pattern.
//
// state | meaning
// IDLE  | waiting for start; results of the last run held
// CLEAR | writing zero to every address
// WRITE | writing the current pattern to the current address
// READ  | presenting the address for read-back
// CHECK | comparing registered read data against the pattern
// DONE  | one-cycle completion state, done asserted
module mem_bist #(
   parameter int          DATA_WIDTH = 8,
   parameter int          ADDR_WIDTH = 16,
   parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH:0]   error_count,
   output logic                  first_fail_valid,
   output logic [ADDR_WIDTH-1:0] first_fail_addr,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_input,
   output logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] data_output
);

   import mem_bist_pkg::*;

   mem_bist_state_t       state_q;
   mem_bist_state_t       state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] pattern_q;
   logic                  done_q;
   logic                  addr_last;
   logic                  start_accept;
   logic                  check_en;

   assign addr_last    = is_last_addr(32'(addr_q), RAM_DEPTH);
   assign start_accept = (state_q == IDLE) && start;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; the terminal-address compare ends each phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   if (addr_last) state_d = WRITE;
         WRITE:   state_d = READ;
         READ:    state_d = CHECK;
         CHECK:   state_d = addr_last ? DONE : WRITE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address counter, pattern register and sticky done flag.
   // The pattern is inverted on every entry into WRITE, so even addresses see all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         pattern_q <= '0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q <= '0;
                  done_q <= 1'b0;
               end
            end
            CLEAR: begin
               if (addr_last) begin
                  addr_q    <= '0;
                  pattern_q <= ~{DATA_WIDTH{PATTERN_INIT}};
               end else begin
                  addr_q <= addr_q + ADDR_WIDTH'(1);
               end
            end
            CHECK: begin
               if (addr_last) begin
                  done_q <= 1'b1;
               end else begin
                  addr_q    <= addr_q + ADDR_WIDTH'(1);
                  pattern_q <= ~pattern_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory-side and status outputs, decoded from registers only.
   always_comb begin
      busy         = 1'b0;
      write_enable = 1'b0;
      data_input   = '0;
      check_en     = 1'b0;
      case (state_q)
         CLEAR: begin
            busy         = 1'b1;
            write_enable = 1'b1;
         end
         WRITE: begin
            busy         = 1'b1;
            write_enable = 1'b1;
            data_input   = pattern_q;
         end
         READ:    busy = 1'b1;
         CHECK: begin
            busy     = 1'b1;
            check_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign address = addr_q;
   assign done    = done_q;
   assign pass    = done_q && (error_count == '0);

   mem_bist_err_log #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_err_log (
      .clk             (clk),
      .reset           (reset),
      .clear           (start_accept),
      .enable          (check_en),
      .address         (addr_q),
      .data_output     (data_output),
      .pattern         (pattern_q),
      .error_count     (error_count),
      .first_fail_valid(first_fail_valid),
      .first_fail_addr (first_fail_addr)
   );

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist with a 16-word registered memory model and fault injection.
module tb_mem_bist;

   localparam int DW         = 8;
   localparam int AW         = 4;
   localparam int DEPTH      = 16;
   localparam int RUN_CYCLES = 64;   // start edge k -> done seen after edge k+64 (cycle k+65)

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, pass, first_fail_valid, write_enable;
   logic [AW:0]   error_count;
   logic [AW-1:0] first_fail_addr, address;
   logic [DW-1:0] data_input, data_output;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // memory model and fault configuration
   logic [DW-1:0] mem [DEPTH];
   bit            ignore_wr [DEPTH];
   bit            stuck_en = 1'b0;
   int            stuck_addr = 0;
   int            stuck_bit = 0;

   typedef struct {
      int start_cyc;
      bit pass;
      int err;
      bit ffv;
      int ffa;
   } exp_t;

   exp_t exp_q[$];
   int   obs_addr[$];
   int   obs_data[$];
   exp_t mon_e;
   logic done_prev = 1'b0;

   mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .error_count     (error_count),
      .first_fail_valid(first_fail_valid),
      .first_fail_addr (first_fail_addr),
      .address         (address),
      .data_input      (data_input),
      .write_enable    (write_enable),
      .data_output     (data_output)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_read(input int a);
      logic [DW-1:0] v;
      v = ignore_wr[a] ? 8'h00 : mem[a];
      if (stuck_en && a == stuck_addr) v[stuck_bit] = 1'b0;
      return v;
   endfunction

   // registered single-port memory
   always @(posedge clk) begin
      if (write_enable) mem[address] <= data_input;
      data_output <= mem_read(int'(address));
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference: even addresses hold 0xFF, odd 0x00; apply the fault rules to what is read back.
   function automatic exp_t model_run(input int sc);
      exp_t          e;
      logic [DW-1:0] written, seen;
      e.start_cyc = sc;
      e.err = 0;
      e.ffv = 1'b0;
      e.ffa = 0;
      for (int a = 0; a < DEPTH; a++) begin
         written = (a % 2 == 0) ? 8'hFF : 8'h00;
         seen    = ignore_wr[a] ? 8'h00 : written;
         if (stuck_en && a == stuck_addr) seen[stuck_bit] = 1'b0;
         if (seen != written) begin
            e.err++;
            if (!e.ffv) begin
               e.ffv = 1'b1;
               e.ffa = a;
            end
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   // monitor: log writes, and score each completed run when done rises
   always @(negedge clk) begin
      if (write_enable) begin
         obs_addr.push_back(int'(address));
         obs_data.push_back(int'(data_input));
      end
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
         end else begin
            int bad;
            mon_e = exp_q.pop_front();
            chk("done_latency", cyc - mon_e.start_cyc, RUN_CYCLES);
            chk("busy_at_done", int'(busy), 0);
            chk("pass", int'(pass), int'(mon_e.pass));
            chk("error_count", int'(error_count), mon_e.err);
            chk("first_fail_valid", int'(first_fail_valid), int'(mon_e.ffv));
            chk("first_fail_addr", int'(first_fail_addr), mon_e.ffa);
            bad = 0;
            if (obs_addr.size() != 2 * DEPTH) begin
               bad = 1000 + obs_addr.size();
            end else begin
               for (int i = 0; i < 2 * DEPTH; i++) begin
                  int ea, ed;
                  ea = i % DEPTH;
                  ed = (i < DEPTH) ? 0 : ((ea % 2 == 0) ? 255 : 0);
                  if (obs_addr[i] != ea || obs_data[i] != ed) bad++;
               end
            end
            chk("write_sequence_errors", bad, 0);
         end
      end
      done_prev = done;
   end

   task automatic do_start(output int sc);
      @(negedge clk);
      obs_addr.delete();
      obs_data.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sc = cyc;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_seen"}, int'(done), 1);
   endtask

   task automatic run_one(input string tag);
      int sc;
      do_start(sc);
      exp_q.push_back(model_run(sc));
      wait_done(tag);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_error_count"}, int'(error_count), 0);
      chk({tag, "_ffv"}, int'(first_fail_valid), 0);
      chk({tag, "_ffa"}, int'(first_fail_addr), 0);
      chk({tag, "_address"}, int'(address), 0);
      chk({tag, "_data_input"}, int'(data_input), 0);
      chk({tag, "_write_enable"}, int'(write_enable), 0);
   endtask

   task automatic clear_faults();
      stuck_en = 1'b0;
      for (int a = 0; a < DEPTH; a++) ignore_wr[a] = 1'b0;
   endtask

   initial begin
      int sc;
      clear_faults();
      repeat (3) @(negedge clk);
      check_reset_values("por");
      reset = 1'b0;

      // good memory
      run_one("good");

      // start in the DONE cycle is ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_busy", int'(busy), 0);
      chk("start_in_done_done", int'(done), 1);

      // stuck-at-0 bit 3 at address 5 (written 0x00): no error
      stuck_en = 1'b1; stuck_addr = 5; stuck_bit = 3;
      run_one("stuck5");

      // same fault at address 4 (written 0xFF): one error
      stuck_addr = 4;
      run_one("stuck4");

      // writes to 2 and 9 ignored
      clear_faults();
      ignore_wr[2] = 1'b1;
      ignore_wr[9] = 1'b1;
      run_one("ignore_2_9");

      // start pulse mid-run at k+20 has no effect
      clear_faults();
      do_start(sc);
      exp_q.push_back(model_run(sc));
      repeat (19) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("midrun_start");

      // reset at k+30 of a faulty run: back to reset values, no result reported
      stuck_en = 1'b1; stuck_addr = 0; stuck_bit = 6;
      do_start(sc);
      repeat (29) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("midrun_reset");
      reset = 1'b0;

      // back-to-back: faulty run, then fault removed
      stuck_addr = 4; stuck_bit = 0;
      run_one("b2b_first");
      @(negedge clk);
      clear_faults();
      do_start(sc);
      chk("b2b_done_cleared", int'(done), 0);
      chk("b2b_count_cleared", int'(error_count), 0);
      chk("b2b_ffv_cleared", int'(first_fail_valid), 0);
      chk("b2b_busy", int'(busy), 1);
      exp_q.push_back(model_run(sc));
      wait_done("b2b_second");

      // randomized fault patterns
      for (int r = 0; r < 5; r++) begin
         int n_ign;
         clear_faults();
         stuck_en   = ($urandom_range(0, 1) == 1);
         stuck_addr = $urandom_range(0, DEPTH - 1);
         stuck_bit  = $urandom_range(0, DW - 1);
         n_ign      = $urandom_range(0, 2);
         for (int i = 0; i < n_ign; i++) ignore_wr[$urandom_range(0, DEPTH - 1)] = 1'b1;
         run_one("random");
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
